// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the CPU sequencer: field widths, opcodes, state encoding, ALU codes.
// Optional SUB opcode is enabled by defining CPU_SUB_EN.
package cpu_pkg;

  localparam int OP_W    = 4;
  localparam int ARG_W   = 3;
  localparam int ARG_N   = 2;
  localparam int INSTR_W = OP_W + ARG_N * ARG_W;
  localparam int REG_NUM = 8;

  localparam logic [OP_W-1:0] OP_LOAD = 4'b0000;
  localparam logic [OP_W-1:0] OP_MOVE = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_e;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    logic res;
    case (op)
      OP_ADD:  res = 1'b1;
      OP_XOR:  res = 1'b1;
`ifdef CPU_SUB_EN
      OP_SUB:  res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] alu_code(input logic [OP_W-1:0] op);
    logic [1:0] res;
    case (op)
      OP_XOR:  res = ALU_XOR;
`ifdef CPU_SUB_EN
      OP_SUB:  res = ALU_SUB;
`endif
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction handshake and datapath control bundle between the sequencer and its datapath.
import cpu_pkg::*;

interface cpu_sequencer_if #(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2
);
  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0] instruction;
  logic                                instr_valid;
  logic                                instr_ready;
  logic [REG_NUM-1:0]                  rin;
  logic [REG_NUM-1:0]                  rout;
  logic                                data_tri;
  logic                                a_en;
  logic                                g_en;
  logic                                g_tri;
  logic [1:0]                          alu_op;
  logic                                busy;
  logic                                done;
  logic                                err;
  logic [7:0]                          retired_cnt;

  modport master (
    output instruction, instr_valid,
    input  instr_ready, rin, rout, data_tri, a_en, g_en, g_tri, alu_op,
    input  busy, done, err, retired_cnt
  );

  modport slave (
    input  instruction, instr_valid,
    output instr_ready, rin, rout, data_tri, a_en, g_en, g_tri, alu_op,
    output busy, done, err, retired_cnt
  );
endinterface

// File: rtl/cpu_sequencer_dec3to8.sv
// Register-index decoder: 3-bit index to one-hot 8, all zero when disabled.
import cpu_pkg::*;

module dec3to8 (
  input  logic               en,
  input  logic [ARG_W-1:0]   idx,
  output logic [REG_NUM-1:0] onehot
);
  // one-hot decode gated by enable
  always_comb begin
    onehot = {REG_NUM{1'b0}};
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = {REG_NUM{1'b0}};
    end
  end
endmodule

// File: rtl/cpu_sequencer.sv
// Four-state control sequencer for a simple bus CPU (LOAD/MOVE/ADD/XOR, SUB with CPU_SUB_EN).
// Datapath enables decode only from the state and the latched instruction.
import cpu_pkg::*;

module cpu_sequencer #(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2
) (
  input logic            clk,
  input logic            rst,
  cpu_sequencer_if.slave bus
);
  localparam int IW = OP_SIZE + ARG_NUM * ARG_SIZE;

  state_e        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [7:0]    retired_q, retired_d;

  logic [OP_SIZE-1:0]  op_s;
  logic [ARG_SIZE-1:0] x_s;
  logic [ARG_SIZE-1:0] y_s;

  logic                rin_en_s, rout_en_s;
  logic [ARG_SIZE-1:0] rin_idx_s, rout_idx_s;
  logic                ready_s, data_tri_s, a_en_s, g_en_s, g_tri_s;
  logic                busy_s, done_s, err_s;
  logic [1:0]          alu_op_s;

  assign op_s = instr_q[IW-1 -: OP_SIZE];
  assign x_s  = instr_q[2*ARG_SIZE-1 -: ARG_SIZE];
  assign y_s  = instr_q[ARG_SIZE-1:0];

  // state, latched instruction and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= {IW{1'b0}};
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // next-state and Moore decode of the datapath controls
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    rin_en_s   = 1'b0;
    rin_idx_s  = x_s;
    rout_en_s  = 1'b0;
    rout_idx_s = x_s;
    data_tri_s = 1'b0;
    a_en_s     = 1'b0;
    g_en_s     = 1'b0;
    g_tri_s    = 1'b0;
    alu_op_s   = ALU_ADD;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    ready_s    = (state_q == ST_IDLE) && rst;

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid && ready_s) begin
          instr_d = bus.instruction;
          state_d = ST_T1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T1: begin
        busy_s = 1'b1;
        if (op_s == OP_LOAD) begin
          rin_en_s   = 1'b1;
          data_tri_s = 1'b1;
          done_s     = 1'b1;
          state_d    = ST_IDLE;
        end else if (op_s == OP_MOVE) begin
          rin_en_s   = 1'b1;
          rout_en_s  = 1'b1;
          rout_idx_s = y_s;
          done_s     = 1'b1;
          state_d    = ST_IDLE;
        end else if (is_alu_op(op_s)) begin
          rout_en_s  = 1'b1;
          a_en_s     = 1'b1;
          state_d    = ST_T2;
        end else begin
          // illegal opcode: flag it and drop the instruction
          err_s      = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_T2: begin
        busy_s     = 1'b1;
        rout_en_s  = 1'b1;
        rout_idx_s = y_s;
        g_en_s     = 1'b1;
        alu_op_s   = alu_code(op_s);
        state_d    = ST_T3;
      end
      ST_T3: begin
        busy_s   = 1'b1;
        g_tri_s  = 1'b1;
        rin_en_s = 1'b1;
        done_s   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (done_s) begin
      retired_d = retired_q + 8'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  dec3to8 u_dec_rin (
    .en     (rin_en_s),
    .idx    (rin_idx_s),
    .onehot (bus.rin)
  );

  dec3to8 u_dec_rout (
    .en     (rout_en_s),
    .idx    (rout_idx_s),
    .onehot (bus.rout)
  );

  assign bus.instr_ready = ready_s;
  assign bus.data_tri    = data_tri_s;
  assign bus.a_en        = a_en_s;
  assign bus.g_en        = g_en_s;
  assign bus.g_tri       = g_tri_s;
  assign bus.alu_op      = alu_op_s;
  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.err         = err_s;
  assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected per-cycle control vectors are queued at issue
// and compared cycle by cycle; SUB expectations follow CPU_SUB_EN.
import cpu_pkg::*;

module tb_cpu_sequencer;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       data_tri;
    logic       a_en;
    logic       g_en;
    logic       g_tri;
    logic [1:0] alu_op;
    logic [7:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.OP_SIZE(4), .ARG_SIZE(3), .ARG_NUM(2)) bus ();

  cpu_sequencer #(.OP_SIZE(4), .ARG_SIZE(3), .ARG_NUM(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  obs_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cnt_m  = 8'd0;

  function automatic obs_t observe();
    obs_t o;
    o.ready    = bus.instr_ready;
    o.busy     = bus.busy;
    o.done     = bus.done;
    o.err      = bus.err;
    o.rin      = bus.rin;
    o.rout     = bus.rout;
    o.data_tri = bus.data_tri;
    o.a_en     = bus.a_en;
    o.g_en     = bus.g_en;
    o.g_tri    = bus.g_tri;
    o.alu_op   = bus.alu_op;
    o.cnt      = bus.retired_cnt;
    return o;
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e;
    e       = '0;
    e.ready = 1'b1;
    e.cnt   = cnt_m;
    return e;
  endfunction

  // reference model: queue the expected vector of every busy cycle of one instruction
  task automatic push_instr(input logic [9:0] ins);
    logic [3:0] op;
    logic [2:0] x, y;
    logic       alu, sub_ok;
    obs_t       e;
    op = ins[9:6];
    x  = ins[5:3];
    y  = ins[2:0];
`ifdef CPU_SUB_EN
    sub_ok = 1'b1;
`else
    sub_ok = 1'b0;
`endif
    alu = (op == 4'b0010) || (op == 4'b0011) || (sub_ok && op == 4'b0100);
    e = '0; e.busy = 1'b1; e.cnt = cnt_m;
    if (op == 4'b0000) begin
      e.rin = oh(x); e.data_tri = 1'b1; e.done = 1'b1;
      exp_q.push_back(e);
      cnt_m = cnt_m + 8'd1;
    end else if (op == 4'b0001) begin
      e.rin = oh(x); e.rout = oh(y); e.done = 1'b1;
      exp_q.push_back(e);
      cnt_m = cnt_m + 8'd1;
    end else if (alu) begin
      e.rout = oh(x); e.a_en = 1'b1;
      exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.cnt = cnt_m;
      e.rout = oh(y); e.g_en = 1'b1;
      e.alu_op = (op == 4'b0011) ? 2'b01 : ((op == 4'b0100) ? 2'b10 : 2'b00);
      exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.cnt = cnt_m;
      e.g_tri = 1'b1; e.rin = oh(x); e.done = 1'b1;
      exp_q.push_back(e);
      cnt_m = cnt_m + 8'd1;
    end else begin
      e.err = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic step_check(input string name);
    obs_t a, e;
    int   n;
    a = observe();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, got %h", name, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s got %h want %h", name, a, e);
      end
    end
    n = $countones(bus.rout) + int'(bus.data_tri) + int'(bus.g_tri);
    checks++;
    if (n > 1) begin
      errors++;
      $display("FAIL %s bus_exclusive drivers=%0d want <=1", name, n);
    end
    @(posedge clk);
    #1;
  endtask

  // issue from IDLE, scramble the live instruction while busy, then drain the scoreboard
  task automatic run_instr(input logic [9:0] ins, input logic hold_valid, input string name);
    obs_t a;
    a = observe();
    checks++;
    if (a !== idle_exp()) begin
      errors++;
      $display("FAIL %s_idle got %h want %h", name, a, idle_exp());
    end
    bus.instruction = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    push_instr(ins);
    bus.instr_valid = hold_valid;
    bus.instruction = 10'($urandom);
    while (exp_q.size() > 0) step_check(name);
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t a;
    bus.instr_valid = 1'b1;
    bus.instruction = 10'b0000_001_000;
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      a = observe();
      checks++;
      if (a !== '0) begin
        errors++;
        $display("FAIL reset_outputs got %h want 0", a);
      end
      @(posedge clk);
      #1;
    end
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cnt_m = 8'd0;
  endtask

  task automatic test_load();
    run_instr(10'b0000_011_000, 1'b1, "load_x3");
    run_instr(10'b0000_000_101, 1'b0, "load_x0");
  endtask

  task automatic test_alu();
    run_instr(10'b0010_001_010, 1'b1, "add_x1_y2");
    run_instr(10'b0011_110_110, 1'b0, "xor_x6_y6");
    run_instr(10'b0010_111_000, 1'b1, "add_x7_y0");
  endtask

  task automatic test_illegal();
    run_instr(10'b0111_010_001, 1'b0, "illegal_0111");
    run_instr(10'b1111_111_111, 1'b1, "illegal_1111");
    run_instr(10'b0000_100_000, 1'b0, "load_after_illegal");
  endtask

  task automatic test_sub();
    run_instr(10'b0100_110_011, 1'b0, "op_0100");
  endtask

  task automatic test_reset_abort();
    obs_t a;
    run_instr(10'b0001_010_011, 1'b0, "move_before_abort");
    bus.instruction = 10'b0011_111_000;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    push_instr(10'b0011_111_000);
    step_check("abort_xor_t1");
    a = observe();
    checks++;
    if (a !== exp_q[0]) begin
      errors++;
      $display("FAIL abort_xor_t2 got %h want %h", a, exp_q[0]);
    end
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    cnt_m = 8'd0;
    for (int i = 0; i < 3; i++) begin
      a = observe();
      checks++;
      if (a !== '0) begin
        errors++;
        $display("FAIL abort_in_reset got %h want 0", a);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      a = observe();
      checks++;
      if (a !== idle_exp()) begin
        errors++;
        $display("FAIL abort_after got %h want %h", a, idle_exp());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) begin
      run_instr(10'b0001_101_101, 1'b0, "move_x5_y5");
    end
    checks++;
    if (bus.retired_cnt !== 8'd0) begin
      errors++;
      $display("FAIL move_wrap retired_cnt=%0d want 0", bus.retired_cnt);
    end
  endtask

  initial begin
    bus.instruction = 10'd0;
    bus.instr_valid = 1'b0;
    test_reset();
    test_load();
    test_alu();
    test_illegal();
    test_sub();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
